// File: rtl/video_timing_detector.sv
// Video timing detector: measures line/frame totals and active area from hsync/vsync/de and
// locks once consecutive frames agree. Define LOCK_COMPARE_EN to also require nominal timing.
module video_timing_detector #(
  parameter int unsigned widthMax    = 1650,
  parameter int unsigned heightMax   = 750,
  parameter int unsigned FRAMEWIDTH  = 1280,
  parameter int unsigned FRAMEHEIGHT = 720,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [11:0] hTotal,
  output logic [11:0] vTotal,
  output logic [11:0] hActive,
  output logic [11:0] vActive,
  output logic        measValid,
  output logic        locked
);

  localparam logic [11:0] CntMax     = 12'hFFF;
  localparam logic [11:0] NomHTotal  = 12'(widthMax);
  localparam logic [11:0] NomVTotal  = 12'(heightMax);
  localparam logic [11:0] NomHActive = 12'(FRAMEWIDTH);
  localparam logic [11:0] NomVActive = 12'(FRAMEHEIGHT);
  localparam logic [7:0]  LockCnt    = 8'(LOCK_FRAMES);
`ifdef LOCK_COMPARE_EN
  localparam bit CompareEn = 1'b1;
`else
  localparam bit CompareEn = 1'b0;
`endif

  typedef enum logic [1:0] {StSearch, StMeasure, StCheck, StLocked} state_e;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CntMax) ? v : v + 12'd1;
  endfunction

  logic hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
  logic h_rise, v_rise, de_fall;

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d, vcnt_cl;
  logic [11:0] vact_q, vact_d, vact_cl;
  logic [11:0] run_q, run_d;
  logic [11:0] hmax_q, hmax_d, hmax_cl;
  logic [11:0] ref_q, ref_d, ref_cl;
  logic        have_ref_q, have_ref_d, have_ref_cl;
  logic        incons_q, incons_d, incons_cl;
  logic        line_start_q, line_start_d;
  logic        line_de_q, line_de_d;

  logic [11:0] frame_ht, frame_ha;
  logic        frame_sat, frame_nominal, frame_match, timeout, latch;

  state_e      state_q, state_d;
  logic [7:0]  match_q, match_d;
  logic [11:0] ht_q, ht_d, vt_q, vt_d, ha_q, ha_d, va_q, va_d;
  logic        meas_valid_q, meas_valid_d, locked_q, locked_d;

  always_ff @(posedge pxlClk or posedge rst) begin
    if (rst) begin
      {hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q} <= '0;
    end else begin
      {hs1_q, vs1_q, de1_q} <= {hsync, vsync, de};
      {hs2_q, vs2_q, de2_q} <= {hs1_q, vs1_q, de1_q};
    end
  end

  assign h_rise  = hs1_q & ~hs2_q;
  assign v_rise  = vs1_q & ~vs2_q;
  assign de_fall = de2_q & ~de1_q;
  assign timeout = (vcnt_q == CntMax) && !v_rise;

  // *_cl values include the current cycle, so a line closed on the vsync rise counts
  // toward the frame that rise ends.
  always_comb begin
    hcnt_d    = h_rise ? 12'd1 : sat_inc(hcnt_q);
    vcnt_cl   = h_rise ? sat_inc(vcnt_q) : vcnt_q;
    vact_cl   = (h_rise && (line_de_q || de1_q)) ? sat_inc(vact_q) : vact_q;
    line_de_d = h_rise ? 1'b0 : (line_de_q || de1_q);
    hmax_cl   = (de_fall && (run_q > hmax_q)) ? run_q : hmax_q;
    run_d     = de1_q ? sat_inc(run_q) : 12'd0;

    ref_cl      = ref_q;
    have_ref_cl = have_ref_q;
    incons_cl   = incons_q;
    if (h_rise && line_start_q) begin
      if (!have_ref_q) begin
        ref_cl      = hcnt_q;
        have_ref_cl = 1'b1;
      end else if (hcnt_q != ref_q) begin
        incons_cl = 1'b1;
      end
    end

    frame_ht      = have_ref_cl ? ref_cl : 12'd0;
    frame_ha      = (run_q > hmax_cl) ? run_q : hmax_cl;
    frame_sat     = (frame_ht == CntMax) || (vcnt_cl == CntMax) ||
                    (frame_ha == CntMax) || (vact_cl == CntMax);
    frame_nominal = (frame_ht == NomHTotal) && (vcnt_cl == NomVTotal) &&
                    (frame_ha == NomHActive) && (vact_cl == NomVActive);
    frame_match   = have_ref_cl && !incons_cl && !frame_sat &&
                    (frame_ht == ht_q) && (vcnt_cl == vt_q) &&
                    (frame_ha == ha_q) && (vact_cl == va_q) &&
                    (!CompareEn || frame_nominal);

    if (v_rise) begin
      vcnt_d       = 12'd0;
      vact_d       = 12'd0;
      hmax_d       = 12'd0;
      run_d        = 12'd0;
      ref_d        = 12'd0;
      have_ref_d   = 1'b0;
      incons_d     = 1'b0;
      // A coincident hsync rise starts the first full line of the new frame.
      line_start_d = h_rise;
    end else begin
      vcnt_d       = vcnt_cl;
      vact_d       = vact_cl;
      hmax_d       = hmax_cl;
      ref_d        = ref_cl;
      have_ref_d   = have_ref_cl;
      incons_d     = incons_cl;
      line_start_d = line_start_q || h_rise;
    end
  end

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    locked_d     = locked_q;
    meas_valid_d = 1'b0;
    ht_d         = ht_q;
    vt_d         = vt_q;
    ha_d         = ha_q;
    va_d         = va_q;
    latch        = 1'b0;

    unique case (state_q)
      StSearch:  if (v_rise) state_d = StMeasure;
      StMeasure: if (v_rise) latch = 1'b1;
      StCheck, StLocked: begin
        if (v_rise) begin
          if (!frame_match) begin
            latch = 1'b1;
          end else if (state_q == StCheck) begin
            match_d = match_q + 8'd1;
            if (match_d >= LockCnt) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end
        end
      end
    endcase

    if (latch) begin
      ht_d         = frame_ht;
      vt_d         = vcnt_cl;
      ha_d         = frame_ha;
      va_d         = vact_cl;
      meas_valid_d = 1'b1;
      match_d      = 8'd0;
      locked_d     = 1'b0;
      state_d      = StCheck;
    end

    if (timeout) begin
      state_d  = StSearch;
      match_d  = 8'd0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge pxlClk or posedge rst) begin
    if (rst) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vact_q       <= '0;
      run_q        <= '0;
      hmax_q       <= '0;
      ref_q        <= '0;
      have_ref_q   <= 1'b0;
      incons_q     <= 1'b0;
      line_start_q <= 1'b0;
      line_de_q    <= 1'b0;
      state_q      <= StSearch;
      match_q      <= '0;
      ht_q         <= '0;
      vt_q         <= '0;
      ha_q         <= '0;
      va_q         <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vact_q       <= vact_d;
      run_q        <= run_d;
      hmax_q       <= hmax_d;
      ref_q        <= ref_d;
      have_ref_q   <= have_ref_d;
      incons_q     <= incons_d;
      line_start_q <= line_start_d;
      line_de_q    <= line_de_d;
      state_q      <= state_d;
      match_q      <= match_d;
      ht_q         <= ht_d;
      vt_q         <= vt_d;
      ha_q         <= ha_d;
      va_q         <= va_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign hTotal    = ht_q;
  assign vTotal    = vt_q;
  assign hActive   = ha_q;
  assign vActive   = va_q;
  assign measValid = meas_valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: a frame table drives scaled-down video streams; a scoreboard
// queue holds expected measurements that are checked on every measValid pulse.
module tb_video_timing_detector;

  // Scaled "720p-like" stream A and "1080p-like" stream B keep the run short.
  localparam int AH = 40, AV = 16, AHA = 24, AVA = 10;
  localparam int BH = 48, BV = 20, BHA = 30, BVA = 14;
`ifdef LOCK_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic        pxlClk = 1'b0;
  logic        rst, hsync, vsync, de;
  logic [11:0] hTotal, vTotal, hActive, vActive;
  logic        measValid, locked;

  video_timing_detector #(
    .widthMax   (AH),
    .heightMax  (AV),
    .FRAMEWIDTH (AHA),
    .FRAMEHEIGHT(AVA),
    .LOCK_FRAMES(2)
  ) dut (
    .pxlClk   (pxlClk),
    .rst      (rst),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .hTotal   (hTotal),
    .vTotal   (vTotal),
    .hActive  (hActive),
    .vActive  (vActive),
    .measValid(measValid),
    .locked   (locked)
  );

  always #5 pxlClk = ~pxlClk;

  typedef struct {
    int ht;
    int vt;
    int ha;
    int va;
  } meas_t;

  // One frame of stimulus plus what the outputs must show once its leading vsync is processed.
  typedef struct {
    bit is_b;
    int voff;
    int bad_line;
    int abort_line;
    int tail;
    bit lock_start;
    bit pulse_end;
  } vec_t;

  meas_t sb[$];
  vec_t  tbl[24];
  int    n_vec = 0;
  int    n_bad = 0;
  bit    prev_pulse = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pxlClk);
    #1;
  endtask

  always @(negedge pxlClk) begin
    if (measValid) begin
      if (sb.size() == 0) begin
        cmp("unexpected_measValid", 1, 0);
      end else begin
        meas_t m;
        m = sb.pop_front();
        cmp("hTotal", int'(hTotal), m.ht);
        cmp("vTotal", int'(vTotal), m.vt);
        cmp("hActive", int'(hActive), m.ha);
        cmp("vActive", int'(vActive), m.va);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    cmp({tag, "_hTotal"}, int'(hTotal), 0);
    cmp({tag, "_vTotal"}, int'(vTotal), 0);
    cmp({tag, "_hActive"}, int'(hActive), 0);
    cmp({tag, "_vActive"}, int'(vActive), 0);
    cmp({tag, "_measValid"}, int'(measValid), 0);
    cmp({tag, "_locked"}, int'(locked), 0);
  endtask

  task automatic drive_frame(input vec_t v);
    int ht, vt, ha, va, len, idx;
    meas_t m;
    ht  = v.is_b ? BH : AH;
    vt  = v.is_b ? BV : AV;
    ha  = v.is_b ? BHA : AHA;
    va  = v.is_b ? BVA : AVA;
    idx = 0;
    for (int l = 0; l < vt; l++) begin
      len = (l == v.bad_line) ? ht + 1 : ht;
      for (int c = 0; c < len; c++) begin
        hsync = (c < 2);
        vsync = (idx >= v.voff) && (idx < v.voff + 2 * ht);
        de    = (l >= 3) && (l < 3 + va) && (c >= 4) && (c < 4 + ha);
        if (l == v.abort_line && c == 5) begin
          rst = 1'b1;
          #1;
          check_all_zero("midframe_rst");
        end
        if (l == v.abort_line && c == 15) rst = 1'b0;
        tick();
        idx++;
        // Pulse lands on the second edge after vsync is first sampled high.
        if (idx == v.voff + 2) cmp("measValid_edge", int'(measValid), int'(prev_pulse));
        if (idx == 8) begin
          cmp("locked", int'(locked), int'(v.lock_start));
          cmp("sb_drained", sb.size(), 0);
          if (v.pulse_end) begin
            m = '{ht, vt, ha, va};
            sb.push_back(m);
          end
        end
      end
    end
    // Short lines with vsync held low until the line count saturates.
    for (int n = 0; n < v.tail; n++) begin
      if (n == 4000) cmp("locked_pre_timeout", int'(locked), int'(v.lock_start));
      for (int c = 0; c < 8; c++) begin
        hsync = (c < 2);
        vsync = 1'b0;
        de    = (c >= 3) && (c < 6);
        tick();
      end
    end
    if (v.tail > 0) cmp("locked_timeout", int'(locked), 0);
    prev_pulse = v.pulse_end;
  endtask

  initial begin
    //          is_b voff bad abort tail  lock_start pulse_end
    tbl[0]  = '{0, 0, -1, -1, 0,    0,    1};
    tbl[1]  = '{0, 0, -1, -1, 0,    0,    0};
    tbl[2]  = '{0, 0, -1, -1, 0,    0,    0};
    tbl[3]  = '{0, 0, -1, -1, 0,    1,    0};
    tbl[4]  = '{0, 0, 5,  -1, 0,    1,    1};
    tbl[5]  = '{0, 0, -1, -1, 0,    0,    0};
    tbl[6]  = '{0, 0, -1, -1, 0,    0,    0};
    tbl[7]  = '{0, 3, -1, -1, 0,    1,    0};
    tbl[8]  = '{1, 0, -1, -1, 0,    1,    1};
    tbl[9]  = '{1, 0, -1, -1, 0,    0,    CMP};
    tbl[10] = '{1, 0, -1, -1, 0,    0,    CMP};
    tbl[11] = '{1, 0, -1, -1, 0,    !CMP, CMP};
    tbl[12] = '{0, 0, -1, -1, 0,    !CMP, 1};
    tbl[13] = '{0, 0, -1, -1, 0,    0,    0};
    tbl[14] = '{0, 0, -1, -1, 0,    0,    0};
    tbl[15] = '{0, 0, -1, 8,  0,    1,    0};
    tbl[16] = '{0, 0, -1, -1, 0,    0,    1};
    tbl[17] = '{0, 0, -1, -1, 0,    0,    0};
    tbl[18] = '{0, 0, -1, -1, 0,    0,    0};
    tbl[19] = '{0, 0, -1, -1, 4100, 1,    0};
    tbl[20] = '{0, 0, -1, -1, 0,    0,    1};
    tbl[21] = '{0, 0, -1, -1, 0,    0,    0};
    tbl[22] = '{0, 0, -1, -1, 0,    0,    0};
    tbl[23] = '{0, 0, -1, -1, 0,    1,    0};

    rst   = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    de    = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 24; i++) drive_frame(tbl[i]);

    hsync = 1'b0;
    vsync = 1'b0;
    de    = 1'b0;
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
